// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC rotator back end.
// Q2.30 data path, gain constant and the per-sample tag carried beside the pipeline.
package cordic_pkg;

  localparam int DATA_W = 32;
  localparam int FRAC_W = 30;
  localparam int STAGES_DEFAULT = 16;
  localparam logic [DATA_W-1:0] K_GAIN_DEFAULT = 32'h26DD3B6A;

  typedef struct packed {
    logic valid;
    logic neg;
  } tag_t;

  typedef struct packed {
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] z;
  } result_t;

  // Signed Q2.30 multiply, floor-truncated back to Q2.30; |k| < 1 so it cannot overflow.
  function automatic logic [DATA_W-1:0] gain_mul(input logic [DATA_W-1:0] v,
                                                 input logic [DATA_W-1:0] k);
    logic signed [2*DATA_W-1:0] a;
    logic signed [2*DATA_W-1:0] b;
    logic signed [2*DATA_W-1:0] p;
    a = {{DATA_W{v[DATA_W-1]}}, v};
    b = {{DATA_W{k[DATA_W-1]}}, k};
    p = a * b;
    return p[FRAC_W +: DATA_W];
  endfunction

endpackage

// File: rtl/cordic_result_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO with no pop is dropped and sets a sticky flag.
// Zero-latency head; when empty the data output keeps showing the last entry popped.
module cordic_result_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] head,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             pop;
  logic             wr_ok;

  assign full  = (count == (AW+1)'(DEPTH));
  assign valid = (count != '0);
  assign pop   = valid && ready;
  assign wr_ok = push && (!full || pop);

  // While empty, the slot behind rd_ptr still holds the most recently popped entry.
  assign head = valid ? mem[rd_ptr] : mem[rd_ptr - AW'(1)];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(wr_ok) - (AW+1)'(pop);
      if (push && !wr_ok) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/cordic_output_stage.sv
// CORDIC back end: tag alignment, gain compensation, half-plane negate, output FIFO.
// Result visible STAGES+3 cycles after in_valid; the pipeline never stalls, a full FIFO drops and flags overflow.
module cordic_output_stage
  import cordic_pkg::*;
#(
  parameter int                STAGES     = STAGES_DEFAULT,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] K_GAIN     = K_GAIN_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_neg,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] y_in,
  input  logic [DATA_W-1:0] z_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] x_out,
  output logic [DATA_W-1:0] y_out,
  output logic [DATA_W-1:0] z_out,
  output logic              overflow
);

  tag_t    tag_pipe [STAGES];
  tag_t    tag_al;
  tag_t    p1_tag;
  result_t p1_res;
  logic    p2_valid;
  result_t p2_res;
  result_t head;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= '{valid: in_valid, neg: in_neg};
      for (int i = 1; i < STAGES; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign tag_al = tag_pipe[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      p1_tag <= '0;
      p1_res <= '0;
    end else begin
      p1_tag <= tag_al;
      if (tag_al.valid) begin
        p1_res.x <= gain_mul(x_in, K_GAIN);
        p1_res.y <= gain_mul(y_in, K_GAIN);
        p1_res.z <= z_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p2_valid <= 1'b0;
      p2_res   <= '0;
    end else begin
      p2_valid <= p1_tag.valid;
      if (p1_tag.valid) begin
        p2_res.x <= p1_tag.neg ? -p1_res.x : p1_res.x;
        p2_res.y <= p1_tag.neg ? -p1_res.y : p1_res.y;
        p2_res.z <= p1_res.z;
      end
    end
  end

  cordic_result_fifo #(
    .WIDTH ($bits(result_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (p2_valid),
    .push_data (p2_res),
    .valid     (out_valid),
    .ready     (out_ready),
    .head      (head),
    .overflow  (overflow)
  );

  assign x_out = head.x;
  assign y_out = head.y;
  assign z_out = head.z;

endmodule
